// File: rtl/p88_loader.sv
// P88 program image loader: parses the download byte stream into section
// (C8) and entry (CA) records, writes section data to DRAM, writes a far JMP
// to the boot ROM for an entry record, and holds the system in reset while
// a download is in progress.
module p88_loader #(
    parameter int ADDR_W   = 20,
    parameter int ROM_BASE = 0
) (
    input  logic              clk_sys,
    input  logic              resetL,
    input  logic              dl_active,
    input  logic              dl_wr,
    input  logic [7:0]        dl_data,
    output logic              dl_wait,
    output logic              load_reset,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    output logic              mem_we,
    output logic              mem_rom,
    input  logic              mem_ack,
    output logic              err,
    output logic              entry_valid
);

    typedef enum logic [2:0] {
        IDLE, CMD, SEC, ENT, DATA, WR, ACK, ROMSEQ
    } state_t;

    state_t            state_q, state_d;
    logic              act_q, act_d;          // dl_active seen last cycle
    logic              drain_q, drain_d;      // download ended during a write
    logic              restart_q, restart_d;  // new download started while draining
    logic [2:0]        hdr_cnt_q, hdr_cnt_d;
    logic [15:0]       seg_q, seg_d;
    logic [15:0]       off_q, off_d;
    logic [15:0]       len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        byte_q, byte_d;
    logic [2:0]        rom_idx_q, rom_idx_d;
    logic              rom_ph_q, rom_ph_d;    // 0 = request, 1 = post-ack
    logic              load_reset_q, load_reset_d;
    logic              err_q, err_d;
    logic              entry_valid_q, entry_valid_d;

    logic              rise, fall, acc;
    logic [20:0]       base_sum;
    logic [7:0]        rom_byte;

    // Next-state, datapath updates and combinational outputs
    always_comb begin
        state_d       = state_q;
        act_d         = dl_active;
        drain_d       = drain_q;
        restart_d     = restart_q;
        hdr_cnt_d     = hdr_cnt_q;
        seg_d         = seg_q;
        off_d         = off_q;
        len_d         = len_q;
        addr_d        = addr_q;
        byte_d        = byte_q;
        rom_idx_d     = rom_idx_q;
        rom_ph_d      = rom_ph_q;
        load_reset_d  = load_reset_q;
        err_d         = err_q;
        entry_valid_d = entry_valid_q;

        mem_we   = 1'b0;
        mem_rom  = 1'b0;
        mem_addr = addr_q;
        mem_din  = byte_q;
        dl_wait  = (state_q == WR) || (state_q == ACK) || (state_q == ROMSEQ);

        rise     = dl_active & ~act_q;
        fall     = ~dl_active & act_q;
        acc      = dl_wr & ~dl_wait & (state_q != IDLE);
        // Real-mode linear address, wrapped to the write address width
        base_sum = {1'b0, seg_q, 4'h0} + {5'h0, off_q};

        // Far JMP opcode followed by offset then segment, little-endian
        case (rom_idx_q)
            3'd0:    rom_byte = 8'hEA;
            3'd1:    rom_byte = off_q[7:0];
            3'd2:    rom_byte = off_q[15:8];
            3'd3:    rom_byte = seg_q[7:0];
            default: rom_byte = seg_q[15:8];
        endcase

        // An end of download during a write lets the write sequence finish
        if (fall && dl_wait) drain_d = 1'b1;
        if (rise && state_q != IDLE) restart_d = 1'b1;

        case (state_q)
            IDLE: begin
                drain_d = 1'b0;
                if (rise || restart_q) begin
                    state_d       = CMD;
                    load_reset_d  = 1'b1;
                    err_d         = 1'b0;
                    entry_valid_d = 1'b0;
                    restart_d     = 1'b0;
                end else begin
                    load_reset_d = 1'b0;
                end
            end
            CMD: begin
                if (!dl_active) begin
                    state_d = IDLE;
                end else if (acc) begin
                    hdr_cnt_d = 3'd0;
                    case (dl_data)
                        8'hC8:   state_d = SEC;
                        8'hCA:   state_d = ENT;
                        default: err_d = 1'b1;
                    endcase
                end
            end
            SEC: begin
                if (!dl_active) begin
                    state_d = IDLE;
                end else if (acc) begin
                    hdr_cnt_d = hdr_cnt_q + 3'd1;
                    case (hdr_cnt_q)
                        3'd0: seg_d[7:0]  = dl_data;
                        3'd1: seg_d[15:8] = dl_data;
                        3'd2: off_d[7:0]  = dl_data;
                        3'd3: off_d[15:8] = dl_data;
                        3'd6: len_d[7:0]  = dl_data;
                        3'd7: begin
                            len_d[15:8] = dl_data;
                            addr_d      = base_sum[ADDR_W-1:0];
                            state_d     = ({dl_data, len_q[7:0]} == 16'd0) ? CMD : DATA;
                        end
                        default: ;
                    endcase
                end
            end
            ENT: begin
                if (!dl_active) begin
                    state_d = IDLE;
                end else if (acc) begin
                    hdr_cnt_d = hdr_cnt_q + 3'd1;
                    case (hdr_cnt_q)
                        3'd0: seg_d[7:0]  = dl_data;
                        3'd1: seg_d[15:8] = dl_data;
                        3'd2: off_d[7:0]  = dl_data;
                        default: begin
                            off_d[15:8] = dl_data;
                            rom_idx_d   = 3'd0;
                            rom_ph_d    = 1'b0;
                            state_d     = ROMSEQ;
                        end
                    endcase
                end
            end
            DATA: begin
                if (!dl_active) begin
                    state_d = IDLE;
                end else if (acc) begin
                    byte_d  = dl_data;
                    state_d = WR;
                end
            end
            WR: begin
                mem_we = 1'b1;
                if (mem_ack) state_d = ACK;
            end
            ACK: begin
                addr_d = addr_q + ADDR_W'(1);
                len_d  = len_q - 16'd1;
                if (drain_q || fall)      state_d = IDLE;
                else if (len_q == 16'd1)  state_d = CMD;
                else                      state_d = DATA;
            end
            ROMSEQ: begin
                if (!rom_ph_q) begin
                    mem_we   = 1'b1;
                    mem_rom  = 1'b1;
                    mem_addr = ADDR_W'(ROM_BASE) + ADDR_W'(rom_idx_q);
                    mem_din  = rom_byte;
                    if (mem_ack) rom_ph_d = 1'b1;
                end else if (rom_idx_q == 3'd4) begin
                    entry_valid_d = 1'b1;
                    state_d       = (drain_q || fall) ? IDLE : CMD;
                end else begin
                    rom_idx_d = rom_idx_q + 3'd1;
                    rom_ph_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_sys or negedge resetL) begin
        if (!resetL) begin
            state_q       <= IDLE;
            act_q         <= 1'b0;
            drain_q       <= 1'b0;
            restart_q     <= 1'b0;
            hdr_cnt_q     <= '0;
            seg_q         <= '0;
            off_q         <= '0;
            len_q         <= '0;
            addr_q        <= '0;
            byte_q        <= '0;
            rom_idx_q     <= '0;
            rom_ph_q      <= 1'b0;
            load_reset_q  <= 1'b0;
            err_q         <= 1'b0;
            entry_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            act_q         <= act_d;
            drain_q       <= drain_d;
            restart_q     <= restart_d;
            hdr_cnt_q     <= hdr_cnt_d;
            seg_q         <= seg_d;
            off_q         <= off_d;
            len_q         <= len_d;
            addr_q        <= addr_d;
            byte_q        <= byte_d;
            rom_idx_q     <= rom_idx_d;
            rom_ph_q      <= rom_ph_d;
            load_reset_q  <= load_reset_d;
            err_q         <= err_d;
            entry_valid_q <= entry_valid_d;
        end
    end

    assign load_reset  = load_reset_q;
    assign err         = err_q;
    assign entry_valid = entry_valid_q;

endmodule
